// File: rtl/bitonic_input_loader.sv
// ----------------------------------------------------------------------------
// bitonic_input_loader
//
// Serial-to-parallel front end for a bitonic sorting network. Words arrive one
// per cycle on a valid/ready stream and are collected into N_INPUTS slots.
// When the frame is complete (all slots written, or a word flagged in_last),
// the whole frame is presented in parallel together with constant index tags,
// the frame direction and the count of real words. Unused slots of a short
// frame are filled with a pad value that sorts to the tail of the frame.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        asynchronous active-low reset
//   flush      synchronous frame abort (highest priority)
//   in_valid   in_data / in_dir / in_last are valid
//   in_ready   loader accepts a word this cycle (FILL state)
//   in_data    serial data word
//   in_dir     sort direction (1 ascending, 0 descending), taken from slot 0
//   in_last    current word ends a short frame
//   out_valid  parallel frame valid (HOLD state)
//   out_ready  downstream accepts the frame
//   out_data   frame data, slot i at [i*DATA_WIDTH +: DATA_WIDTH]
//   out_idx    index tags, slot i carries the value i
//   out_dir    latched frame direction
//   out_count  number of real (non-pad) words, 1..N_INPUTS
// ----------------------------------------------------------------------------
module bitonic_input_loader #(
  parameter int DATA_WIDTH  = 32,
  parameter int N_INPUTS    = 8,
  parameter int INDEX_WIDTH = $clog2(N_INPUTS)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_WIDTH-1:0]             in_data,
  input  logic                              in_dir,
  input  logic                              in_last,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [N_INPUTS*DATA_WIDTH-1:0]    out_data,
  output logic [N_INPUTS*INDEX_WIDTH-1:0]   out_idx,
  output logic                              out_dir,
  output logic [INDEX_WIDTH:0]              out_count
);

  localparam logic [0:0] S_FILL = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  localparam logic [INDEX_WIDTH-1:0] LAST_SLOT = INDEX_WIDTH'(N_INPUTS - 1);
  localparam logic [INDEX_WIDTH-1:0] PTR_ONE   = INDEX_WIDTH'(1);
  localparam logic [INDEX_WIDTH:0]   CNT_ONE   = (INDEX_WIDTH + 1)'(1);

  // Pad value: all ones for ascending frames, all zeros for descending, so
  // pads always end up behind the real words after sorting.
  function automatic logic [DATA_WIDTH-1:0] pad_value(input logic dir);
    return {DATA_WIDTH{dir}};
  endfunction

  logic [0:0]             state;
  logic [INDEX_WIDTH-1:0] wr_ptr;
  logic                   accept;
  logic                   at_last_slot;
  logic                   frame_done;
  logic                   pad_dir;

  assign in_ready  = (state == S_FILL);
  assign out_valid = (state == S_HOLD);

  // flush suppresses acceptance in its own cycle
  assign accept       = in_valid & in_ready & ~flush;
  assign at_last_slot = (wr_ptr == LAST_SLOT);
  assign frame_done   = accept & (at_last_slot | in_last);

  // A one-word frame pads using the direction arriving with that same word,
  // because out_dir is only updated at the end of this cycle.
  assign pad_dir = (wr_ptr == '0) ? in_dir : out_dir;

  // Control: state, write pointer, direction and count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_FILL;
      wr_ptr    <= '0;
      out_dir   <= 1'b0;
      out_count <= '0;
    end else if (flush) begin
      state  <= S_FILL;
      wr_ptr <= '0;
    end else if (state == S_FILL) begin
      if (accept) begin
        if (wr_ptr == '0) begin
          out_dir <= in_dir;
        end
        if (frame_done) begin
          state     <= S_HOLD;
          wr_ptr    <= '0;
          out_count <= {1'b0, wr_ptr} + CNT_ONE;
        end else begin
          wr_ptr <= wr_ptr + PTR_ONE;
        end
      end
    end else if (out_ready) begin
      state  <= S_FILL;
      wr_ptr <= '0;
    end
  end

  // Slot registers: each slot only loads on an accepted word, either with the
  // word itself (its own slot) or with the pad value (slots beyond a short
  // frame's last word). Nothing toggles while the frame is held.
  for (genvar i = 0; i < N_INPUTS; i++) begin : g_slot
    localparam logic [INDEX_WIDTH-1:0] SLOT = INDEX_WIDTH'(i);

    logic [DATA_WIDTH-1:0] slot_q;
    logic                  wr_en;
    logic                  pad_en;

    assign wr_en  = accept & (wr_ptr == SLOT);
    assign pad_en = accept & in_last & (SLOT > wr_ptr);

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        slot_q <= '0;
      end else if (wr_en) begin
        slot_q <= in_data;
      end else if (pad_en) begin
        slot_q <= pad_value(pad_dir);
      end
    end

    assign out_data[i*DATA_WIDTH +: DATA_WIDTH]   = slot_q;
    assign out_idx[i*INDEX_WIDTH +: INDEX_WIDTH] = SLOT;
  end

endmodule

// File: tb/tb_bitonic_input_loader.sv
// ----------------------------------------------------------------------------
// tb_bitonic_input_loader
//
// Directed bench for bitonic_input_loader with N_INPUTS=8, DATA_WIDTH=32.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// ----------------------------------------------------------------------------
module tb_bitonic_input_loader;

  localparam int DW = 32;
  localparam int N  = 8;
  localparam int IW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data;
  logic            in_dir;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [N*DW-1:0] out_data;
  logic [N*IW-1:0] out_idx;
  logic            out_dir;
  logic [IW:0]     out_count;

  int n_checks = 0;
  int n_fail   = 0;

  bitonic_input_loader #(
    .DATA_WIDTH (DW),
    .N_INPUTS   (N),
    .INDEX_WIDTH(IW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_dir   (in_dir),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_idx  (out_idx),
    .out_dir  (out_dir),
    .out_count(out_count)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] slot(input int i);
    return out_data[i*DW +: DW];
  endfunction

  function automatic logic [IW-1:0] idx(input int i);
    return out_idx[i*IW +: IW];
  endfunction

  task automatic send_word(input logic [DW-1:0] d, input logic dir, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_dir   = dir;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic release_frame();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
    in_dir = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    #12;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_checks++;
    if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    n_checks++;
    if (out_count !== 4'd0) begin n_fail++; $display("FAIL reset_out_count: got %0d expected 0", out_count); end
    n_checks++;
    if (out_dir !== 1'b0) begin n_fail++; $display("FAIL reset_out_dir: got %b expected 0", out_dir); end
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_full_frame();
    logic [DW-1:0] exp_d;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      send_word(DW'(8 - i), 1'b1, 1'b0);
      if (i == N - 2) begin
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL full_early_valid: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready);
        end
      end
    end
    n_checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_latency: got valid=%b ready=%b expected valid=1 ready=0", out_valid, in_ready);
    end
    for (int i = 0; i < N; i++) begin
      exp_d = DW'(8 - i);
      n_checks++;
      if (slot(i) !== exp_d) begin n_fail++; $display("FAIL full_slot%0d: got %h expected %h", i, slot(i), exp_d); end
      n_checks++;
      if (idx(i) !== IW'(i)) begin n_fail++; $display("FAIL full_idx%0d: got %0d expected %0d", i, idx(i), i); end
    end
    n_checks++;
    if (out_count !== 4'd8) begin n_fail++; $display("FAIL full_count: got %0d expected 8", out_count); end
    n_checks++;
    if (out_dir !== 1'b1) begin n_fail++; $display("FAIL full_dir: got %b expected 1", out_dir); end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL full_return_fill: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready);
    end
  endtask

  task automatic test_short_frame();
    logic [DW-1:0] exp_d [N];
    // descending: pads are zero
    send_word(32'd5, 1'b0, 1'b0);
    send_word(32'd9, 1'b0, 1'b0);
    send_word(32'd3, 1'b0, 1'b1);
    exp_d = '{32'd5, 32'd9, 32'd3, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL short_desc_valid: got %b expected 1", out_valid); end
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (slot(i) !== exp_d[i]) begin n_fail++; $display("FAIL short_desc_slot%0d: got %h expected %h", i, slot(i), exp_d[i]); end
    end
    n_checks++;
    if (out_count !== 4'd3) begin n_fail++; $display("FAIL short_desc_count: got %0d expected 3", out_count); end
    n_checks++;
    if (out_dir !== 1'b0) begin n_fail++; $display("FAIL short_desc_dir: got %b expected 0", out_dir); end
    release_frame();
    // ascending: pads are all ones
    send_word(32'd5, 1'b1, 1'b0);
    send_word(32'd9, 1'b1, 1'b0);
    send_word(32'd3, 1'b1, 1'b1);
    exp_d = '{32'd5, 32'd9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (slot(i) !== exp_d[i]) begin n_fail++; $display("FAIL short_asc_slot%0d: got %h expected %h", i, slot(i), exp_d[i]); end
      n_checks++;
      if (idx(i) !== IW'(i)) begin n_fail++; $display("FAIL short_asc_idx%0d: got %0d expected %0d", i, idx(i), i); end
    end
    n_checks++;
    if (out_count !== 4'd3) begin n_fail++; $display("FAIL short_asc_count: got %0d expected 3", out_count); end
    n_checks++;
    if (out_dir !== 1'b1) begin n_fail++; $display("FAIL short_asc_dir: got %b expected 1", out_dir); end
    release_frame();
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < N; i++) send_word(DW'(10 + i), 1'b1, 1'b0);
    in_valid = 1'b1; in_data = 32'd99; in_dir = 1'b0; in_last = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold_c%0d: got ready=%b valid=%b expected ready=0 valid=1", c, in_ready, out_valid);
      end
      n_checks++;
      if (slot(0) !== 32'd10 || slot(7) !== 32'd17 || out_count !== 4'd8 || out_dir !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_stable_c%0d: got s0=%0d s7=%0d cnt=%0d dir=%b expected s0=10 s7=17 cnt=8 dir=1",
                 c, slot(0), slot(7), out_count, out_dir);
      end
    end
    release_frame();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_after_release: got ready=%b valid=%b expected ready=1 valid=0", in_ready, out_valid);
    end
    // pending word 99 is accepted now, into slot 0, as a one-word frame
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || slot(0) !== 32'd99 || out_count !== 4'd1 || out_dir !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_next_word: got valid=%b s0=%0d cnt=%0d dir=%b expected valid=1 s0=99 cnt=1 dir=0",
               out_valid, slot(0), out_count, out_dir);
    end
    for (int i = 1; i < N; i++) begin
      n_checks++;
      if (slot(i) !== 32'd0) begin n_fail++; $display("FAIL bp_pad%0d: got %h expected 0", i, slot(i)); end
    end
    release_frame();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) send_word(DW'(1 + i), 1'b1, 1'b0);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_state: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready);
    end
    send_word(32'd42, 1'b0, 1'b1);
    n_checks++;
    if (out_valid !== 1'b1 || slot(0) !== 32'd42 || out_count !== 4'd1 || out_dir !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_relatch: got valid=%b s0=%0d cnt=%0d dir=%b expected valid=1 s0=42 cnt=1 dir=0",
               out_valid, slot(0), out_count, out_dir);
    end
    n_checks++;
    if (slot(1) !== 32'd0 || slot(3) !== 32'd0) begin
      n_fail++;
      $display("FAIL flush_pad: got s1=%h s3=%h expected 0 0", slot(1), slot(3));
    end
    release_frame();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) send_word(DW'(1 + i), 1'b1, 1'b0);
    rst = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || slot(0) !== 32'd0 || out_dir !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_mid_frame: got valid=%b ready=%b s0=%0d dir=%b expected valid=0 ready=1 s0=0 dir=0",
               out_valid, in_ready, slot(0), out_dir);
    end
    #4;
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) send_word(DW'(21 + i), 1'b0, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || out_count !== 4'd8 || out_dir !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_next_frame: got valid=%b cnt=%0d dir=%b expected valid=1 cnt=8 dir=0",
               out_valid, out_count, out_dir);
    end
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (slot(i) !== DW'(21 + i)) begin n_fail++; $display("FAIL arst_slot%0d: got %0d expected %0d", i, slot(i), 21 + i); end
    end
    // reset while a frame is held drops out_valid without waiting for an edge
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_count !== 4'd0) begin
      n_fail++;
      $display("FAIL arst_in_hold: got valid=%b cnt=%0d expected valid=0 cnt=0", out_valid, out_count);
    end
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < N - 1; i++) send_word(DW'(1 + i), 1'b1, 1'b0);
    flush = 1'b1;
    send_word(32'd8, 1'b1, 1'b0);
    flush = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL sim_flush_8th: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready);
    end
    for (int i = 0; i < N; i++) send_word(DW'(50 + i), 1'b1, (i == N - 1));
    n_checks++;
    if (out_valid !== 1'b1 || out_count !== 4'd8 || out_dir !== 1'b1) begin
      n_fail++;
      $display("FAIL sim_last_8th: got valid=%b cnt=%0d dir=%b expected valid=1 cnt=8 dir=1",
               out_valid, out_count, out_dir);
    end
    n_checks++;
    if (slot(0) !== 32'd50 || slot(7) !== 32'd57) begin
      n_fail++;
      $display("FAIL sim_slots: got s0=%0d s7=%0d expected s0=50 s7=57", slot(0), slot(7));
    end
    release_frame();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL sim_release: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_short_frame();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_simultaneous();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bitonic_input_loader.md
BITONIC_INPUT_LOADER -- requirements
Module: bitonic_input_loader

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, width of one data word.
REQ-002 The block SHALL have parameter N_INPUTS, default 8, words per sort frame (power of two, >=2).
REQ-003 The block SHALL have parameter INDEX_WIDTH, default $clog2(N_INPUTS), width of one index tag.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows.
REQ-005 clk  input  1  clock; all state changes on the rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 flush  input  1  synchronous frame abort.
REQ-008 in_valid  input  1  in_data, in_dir and in_last are valid.
REQ-009 in_ready  output  1  the loader accepts a word this cycle.
REQ-010 in_data  input  DATA_WIDTH  serial data word.
REQ-011 in_dir  input  1  sort direction for the frame: 1 ascending, 0 descending.
REQ-012 in_last  input  1  the current word is the last word of a short frame.
REQ-013 out_valid  output  1  the parallel frame is valid.
REQ-014 out_ready  input  1  the downstream compare-and-swap network accepts the frame.
REQ-015 out_data  output  N_INPUTS*DATA_WIDTH  frame data; slot i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-016 out_idx  output  N_INPUTS*INDEX_WIDTH  index tags; slot i carries the value i.
REQ-017 out_dir  output  1  latched frame direction.
REQ-018 out_count  output  INDEX_WIDTH+1  number of real (non-pad) words in the frame, 1..N_INPUTS.

Function
REQ-019 The block SHALL have two states: FILL (collecting words) and HOLD (frame presented).
REQ-020 In FILL: in_ready SHALL be 1 and out_valid SHALL be 0. In HOLD: in_ready SHALL be 0 and out_valid SHALL be 1.
REQ-021 A word SHALL be accepted when in_valid and in_ready are both 1; it is written to slot wr_ptr, and wr_ptr increments by 1.
REQ-022 in_dir SHALL be latched into out_dir only when the word for slot 0 is accepted; in_dir on later words is ignored.
REQ-023 If the accepted word fills slot N_INPUTS-1, the state SHALL be HOLD in the next cycle and out_count SHALL be N_INPUTS, whatever the value of in_last.
REQ-024 If the accepted word has in_last=1 and fills slot k < N_INPUTS-1, then in the next cycle slots k+1..N_INPUTS-1 SHALL hold the pad value, out_count SHALL be k+1, and the state SHALL be HOLD.
REQ-025 The pad value SHALL be all ones when out_dir=1 and all zeros when out_dir=0, so that pads sort to the tail of the frame.
REQ-026 Latency: out_valid SHALL rise exactly one cycle after the completing word is accepted.
REQ-027 In HOLD, out_data, out_idx, out_dir and out_count SHALL stay stable until out_valid and out_ready are both 1.
REQ-028 On HOLD with out_ready=1, the next state SHALL be FILL with wr_ptr=0; in_ready becomes 1 one cycle after the handshake, so there is no bypass path.
REQ-029 out_idx SHALL be constant: slot i always carries the value i (INDEX_WIDTH bits), including pad slots.
REQ-030 flush=1 SHALL have priority over every other event: next state FILL, wr_ptr=0, out_valid=0, and no word accepted in that cycle; slot data need not be cleared.
REQ-031 Slot writes SHALL be gated by the accept condition, so that no register toggles in HOLD (low-power requirement).

Reset
REQ-032 While rst=0: state=FILL, wr_ptr=0, out_valid=0, in_ready=1 after release, out_data=0, out_dir=0, out_count=0.
REQ-033 Reset SHALL take effect asynchronously, including in the middle of a frame, and SHALL discard any partial frame.

Verification
REQ-034 Full frame: N=8, in_dir=1, words 8,7,...,1 sent back-to-back with out_ready=1 -> out_valid rises one cycle after the 8th word, out_data slots = 8..1, out_idx = 0..7, out_count = 8, out_dir = 1.
REQ-035 Short frame: in_dir=0, words 5,9,3 with in_last on the 3rd word -> slots = 5,9,3,0,0,0,0,0, out_count = 3; repeat with in_dir=1 -> pads = 0xFFFFFFFF.
REQ-036 Backpressure: out_ready held at 0 for 10 cycles in HOLD while in_valid=1 -> in_ready stays 0, outputs stable, no word lost; after out_ready=1, the next word goes to slot 0.
REQ-037 Flush mid-frame: flush after 4 words -> the next word lands in slot 0 and out_dir is re-latched from that word.
REQ-038 Asynchronous reset mid-frame: rst=0 for one half-cycle after 5 words -> out_valid=0 immediately, and a following full frame is correct.
REQ-039 Simultaneous events: flush=1 on the cycle of the 8th word -> word not accepted, no HOLD entry; in_last=1 on the 8th word -> out_count = 8.
